// File: rtl/dmem_stage.sv
// M-stage data-memory interface: turns one load/store per instruction into a req/ack bus access.
// Optional `DMEM_TIMEOUT_EN aborts a BUSY access after TIMEOUT cycles without mem_ack and flags ErrM.
module dmem_stage #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        ErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] rdata_q;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic        access;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  lane_byte;

  assign access = MemWriteM | MemReadM;

  // Byte stores replicate the low byte on every lane; the enables pick the one that lands.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = WriteDataM;
    if (ByteM) begin
      be_d    = 4'b0001 << ALUOutM[1:0];
      wdata_d = {4{WriteDataM[7:0]}};
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rdata_q   <= '0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
`ifdef DMEM_TIMEOUT_EN
      err_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef DMEM_TIMEOUT_EN
          err_q <= 1'b0;
          cnt_q <= '0;
`endif
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUOutM[31:2], 2'b00};
            mem_wdata <= wdata_d;
            mem_be    <= be_d;
            byte_q    <= ByteM;
            lane_q    <= ALUOutM[1:0];
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          // An ack landing on the timeout cycle still completes the access normally.
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            mem_req <= 1'b0;
            state_q <= DONE;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (timeout) begin
            rdata_q <= '0;
            mem_req <= 1'b0;
            err_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
`ifdef DMEM_TIMEOUT_EN
          err_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef DMEM_TIMEOUT_EN
  assign err_q = 1'b0;
`endif

  always_comb begin
    case (lane_q)
      2'd0:    lane_byte = rdata_q[7:0];
      2'd1:    lane_byte = rdata_q[15:8];
      2'd2:    lane_byte = rdata_q[23:16];
      default: lane_byte = rdata_q[31:24];
    endcase
  end

  // Result is only presented in DONE, and only for a plain load that was not aborted.
  always_comb begin
    ReadDataM = '0;
    if ((state_q == DONE) && !mem_we && !err_q) begin
      ReadDataM = byte_q ? {24'h0, lane_byte} : rdata_q;
    end
  end

  assign StallM = ((state_q == IDLE) && access) || (state_q == BUSY);
  assign ErrM   = err_q;

`ifndef SYNTHESIS
  localparam logic CFG_OK = ((64'd1 << CNT_W) > 64'(TIMEOUT));

  a_cfg_ok: assert property (@(posedge clk) CFG_OK);

  a_req_is_busy: assert property (@(posedge clk) mem_req == (state_q == BUSY));

  a_bus_stable: assert property (@(posedge clk) disable iff (reset)
    (state_q == BUSY) |=> (state_q != BUSY) ||
      $stable({mem_we, mem_addr, mem_wdata, mem_be}));
`endif

endmodule

// File: doc/dmem_stage.md
Name: dmem_stage

Overview:
- Memory-stage data-memory interface for the 5-stage pipelined ARM core.
- Sits directly downstream of the datapath's E/M register. It consumes ALUOutM (address), WriteDataM and the M-stage memory controls, and drives a req/ack data-memory bus.
- Returns ReadDataM to the datapath's M/W register.
- Asserts StallM to the hazard unit while a multi-cycle access is outstanding. Supports word and byte (LDRB/STRB) accesses.

Parameters:
TIMEOUT, 255, cycles in BUSY without mem_ack before abort (used only with DMEM_TIMEOUT_EN)
CNT_W, 8, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
MemWriteM  input  1  M-stage store request
MemReadM  input  1  M-stage load request (MemtoRegM)
ByteM  input  1  1 = byte access, 0 = word access
ALUOutM  input  32  byte address
WriteDataM  input  32  store data
ReadDataM  output  32  load result to datapath M/W register
StallM  output  1  hold F/D/E/M stages this cycle
ErrM  output  1  access aborted by timeout (only with DMEM_TIMEOUT_EN; else tied 0)
mem_req  output  1  bus request, registered
mem_we  output  1  bus write enable, registered
mem_addr  output  32  word-aligned bus address, registered
mem_wdata  output  32  bus write data, registered
mem_be  output  4  byte enables, registered
mem_rdata  input  32  bus read data, valid when mem_ack=1
mem_ack  input  1  bus completion, single-cycle pulse

Behaviour:
- Clock port is clk. Reset port is reset: one clock, synchronous, active-high.
- FSM states: IDLE, BUSY, DONE. Reset places the FSM in IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, read hold register=0, ErrM=0. StallM=0, ReadDataM=0.
- Reset mid-access: state goes to IDLE and mem_req drops on the same edge. Any later mem_ack is ignored.
- IDLE, Access = MemWriteM|MemReadM:
  - If Access=1: StallM=1 combinationally; register the bus outputs; next state BUSY.
  - If Access=0: StallM=0; ReadDataM=0.
- BUSY:
  - mem_req=1; StallM=1.
  - On mem_ack: capture mem_rdata into the hold register; drop mem_req; next state DONE.
  - Ack in the same cycle mem_req first rises is legal.
- DONE:
  - StallM=0; ReadDataM driven from the hold register, lane-extracted. The pipeline advances this cycle.
  - Next state IDLE unconditionally. A new access is first seen in IDLE on the following cycle.
- Latency: minimum 3 cycles per access (IDLE, BUSY with immediate ack, DONE), of which 2 are stall cycles.
- Both MemWriteM and MemReadM set: treated as a store; ReadDataM=0 in DONE.
- mem_ack in IDLE or DONE: ignored.
- Address: mem_addr={ALUOutM[31:2],2'b00}. ALUOutM[1:0] is registered internally for the lane select.
- Word access:
  - mem_be=4'b1111; mem_wdata=WriteDataM.
  - Load returns the full word. Low address bits are ignored; no alignment fault.
- Byte access:
  - mem_be=4'b0001<<ALUOutM[1:0]; mem_wdata={4{WriteDataM[7:0]}}.
  - Load returns the selected byte lane zero-extended to 32 bits: lane 0=[7:0], 1=[15:8], 2=[23:16], 3=[31:24].
- mem_we=MemWriteM, registered at the IDLE→BUSY edge. All bus outputs hold stable while in BUSY.
- Stores also pass through DONE (one non-stall cycle) to keep the FSM uniform.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- When defined:
  - Counter cleared on entry to BUSY, increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT: drop mem_req, go to DONE with ReadDataM=0, and set ErrM=1 for that DONE cycle only.
  - An ack arriving in the same cycle as the timeout wins; ErrM stays 0.
- When undefined: no counter logic; BUSY waits indefinitely; ErrM tied 0.

Test Plan:
- Word load, addr 0x100, mem_rdata=0xDEADBEEF, ack 1st BUSY cycle → mem_addr=0x100, mem_be=4'hF, StallM high 2 cycles, ReadDataM=0xDEADBEEF in DONE.
- Byte store, addr 0x203, WriteDataM=0x12345678, ack after 3 cycles → mem_addr=0x200, mem_be=4'b1000, mem_wdata=0x78787878, mem_we=1, StallM high 4 cycles.
- Byte load, addr 0x102, mem_rdata=0xAABBCCDD → ReadDataM=0x000000BB.
- Back-to-back load then store, each acked immediately → second mem_req rises exactly 3 cycles after the first; no overlap of requests.
- reset asserted during BUSY, then mem_ack pulsed after release → mem_req=0 the cycle after reset, state IDLE, StallM=0, ReadDataM=0, late ack has no effect.
- DMEM_TIMEOUT_EN with TIMEOUT=4, ack never arrives → mem_req drops after 4 BUSY cycles; ErrM=1 and ReadDataM=0 for one cycle. Without the macro: StallM stays 1 for 20+ cycles.
